// File: rtl/mem_resp_pkg.sv
// Shared types and helpers for the word-addressed memory responder.
package mem_resp_pkg;

  localparam int WORD_W = 32;
  localparam int ADDR_W = 32;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    RESP = 2'd2
  } state_t;

  function automatic logic is_aligned(input logic [ADDR_W-1:0] addr);
    return (addr[1:0] == 2'b00);
  endfunction

endpackage

// File: rtl/mem_resp_array.sv
// Single-port synchronous word storage: write enable, registered read, no reset.
module mem_resp_array
  import mem_resp_pkg::*;
#(
  parameter int DEPTH_WORDS = 64,
  parameter int IDX_W       = 6
) (
  input  logic              clk,
  input  logic              en,
  input  logic              we,
  input  logic [IDX_W-1:0]  idx,
  input  logic [WORD_W-1:0] wdata,
  output logic [WORD_W-1:0] rdata
);

  logic [WORD_W-1:0] mem [DEPTH_WORDS];

  always_ff @(posedge clk) begin
    if (en) begin
      if (we) begin
        mem[idx] <= wdata;
      end else begin
        rdata <= mem[idx];
      end
    end
  end

endmodule

// File: rtl/mem_responder.sv
// Data-memory responder: one request at a time, fixed access latency, range/alignment errors.
// Optional MEM_RESP_ERR_COUNT_EN adds a saturating err_count output.
//
// state | meaning
// IDLE  | req_ready high, waiting for a request
// BUSY  | latency countdown; array access on the cycle the counter reads 0
// RESP  | first cycle loads the response from the array, then holds it until resp_ready
module mem_responder
  import mem_resp_pkg::*;
#(
  parameter int DEPTH_WORDS = 64,
  parameter int BASE_ADDR   = 0,
  parameter int LATENCY     = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_write,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [WORD_W-1:0] req_wdata,
  output logic              resp_valid,
  input  logic              resp_ready,
  output logic [WORD_W-1:0] resp_rdata,
  output logic              resp_err
`ifdef MEM_RESP_ERR_COUNT_EN
  ,
  output logic [7:0]        err_count
`endif
);

  localparam int IDX_W = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
  localparam logic [ADDR_W:0] BASE_EXT = (ADDR_W+1)'(BASE_ADDR);
  localparam logic [ADDR_W:0] END_EXT  = BASE_EXT + (ADDR_W+1)'(DEPTH_WORDS) * (ADDR_W+1)'(4);

  state_t            state;
  logic [3:0]        cnt;
  logic [ADDR_W-1:0] addr_q;
  logic [WORD_W-1:0] wdata_q;
  logic              write_q;
  logic              err_q;

  logic              req_err;
  logic              arr_en;
  logic [IDX_W-1:0]  arr_idx;
  logic [WORD_W-1:0] arr_rdata;
  logic              resp_hs;

  // Range check done one bit wider so BASE_ADDR+4*DEPTH_WORDS cannot wrap.
  assign req_err = !is_aligned(req_addr)
                || ({1'b0, req_addr} < BASE_EXT)
                || ({1'b0, req_addr} >= END_EXT);

  assign arr_en  = (state == BUSY) && (cnt == 4'd0) && !err_q;
  assign arr_idx = IDX_W'((addr_q - ADDR_W'(BASE_ADDR)) >> 2);
  assign resp_hs = (state == RESP) && resp_valid && resp_ready;

  mem_resp_array #(
    .DEPTH_WORDS (DEPTH_WORDS),
    .IDX_W       (IDX_W)
  ) u_array (
    .clk   (clk),
    .en    (arr_en),
    .we    (write_q),
    .idx   (arr_idx),
    .wdata (wdata_q),
    .rdata (arr_rdata)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      cnt        <= 4'd0;
      addr_q     <= '0;
      wdata_q    <= '0;
      write_q    <= 1'b0;
      err_q      <= 1'b0;
      req_ready  <= 1'b1;
      resp_valid <= 1'b0;
      resp_rdata <= '0;
      resp_err   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          req_ready <= 1'b1;
          if (req_valid && req_ready) begin
            addr_q    <= req_addr;
            wdata_q   <= req_wdata;
            write_q   <= req_write;
            err_q     <= req_err;
            cnt       <= 4'(LATENCY - 1);
            req_ready <= 1'b0;
            state     <= BUSY;
          end
        end
        BUSY: begin
          if (cnt == 4'd0) begin
            state <= RESP;
          end else begin
            cnt <= cnt - 4'd1;
          end
        end
        RESP: begin
          // The registered array read lands during the first RESP cycle.
          if (!resp_valid) begin
            resp_valid <= 1'b1;
            resp_err   <= err_q;
            resp_rdata <= (!write_q && !err_q) ? arr_rdata : '0;
          end else if (resp_ready) begin
            resp_valid <= 1'b0;
            resp_err   <= 1'b0;
            resp_rdata <= '0;
            req_ready  <= 1'b1;
            state      <= IDLE;
          end
        end
        default: begin
          state     <= IDLE;
          req_ready <= 1'b1;
        end
      endcase
    end
  end

`ifdef MEM_RESP_ERR_COUNT_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      err_count <= 8'd0;
    end else if (resp_hs && resp_err && (err_count != 8'hff)) begin
      err_count <= err_count + 8'd1;
    end
  end
`endif

endmodule

// File: tb/tb_mem_responder.sv
// Scoreboard bench for mem_responder: directed protocol cases plus randomized traffic.
module tb_mem_responder;

  localparam int DEPTH = 64;
  localparam int BASE  = 0;
  localparam int LAT   = 2;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic        req_write = 1'b0;
  logic [31:0] req_addr  = '0;
  logic [31:0] req_wdata = '0;
  logic        resp_valid;
  logic        resp_ready = 1'b0;
  logic [31:0] resp_rdata;
  logic        resp_err;
`ifdef MEM_RESP_ERR_COUNT_EN
  logic [7:0]  err_count;
`endif

  mem_responder #(
    .DEPTH_WORDS (DEPTH),
    .BASE_ADDR   (BASE),
    .LATENCY     (LAT)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_write  (req_write),
    .req_addr   (req_addr),
    .req_wdata  (req_wdata),
    .resp_valid (resp_valid),
    .resp_ready (resp_ready),
    .resp_rdata (resp_rdata),
    .resp_err   (resp_err)
`ifdef MEM_RESP_ERR_COUNT_EN
    ,
    .err_count  (err_count)
`endif
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [31:0] rdata;
    bit          chk;
    bit          err;
    int          acc;
  } exp_t;

  exp_t        sb[$];
  int          n_cmp = 0;
  int          n_bad = 0;
  int          model_errs = 0;
  logic [31:0] mdl[DEPTH];
  bit          known[DEPTH];
  bit          rr_force0 = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: got %h want %h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  task automatic fail_now(input string name);
    n_cmp++;
    n_bad++;
    $display("FAIL %s (cycle %0d)", name, cyc);
  endtask

  function automatic bit exp_err(input logic [31:0] a);
    longint unsigned la = a;
    return (la % 4 != 0) || (la < BASE) || (la >= BASE + 4 * DEPTH);
  endfunction

  // Drive one request, wait for acceptance, and record what the response must be.
  task automatic req(input bit w, input logic [31:0] a, input logic [31:0] d);
    bit   ok;
    exp_t e;
    int   idx;
    @(negedge clk);
    req_valid = 1'b1;
    req_write = w;
    req_addr  = a;
    req_wdata = d;
    ok = 1'b0;
    for (int i = 0; i < 200; i++) begin
      if (req_ready) begin
        ok = 1'b1;
        break;
      end
      @(negedge clk);
    end
    if (!ok) begin
      fail_now("accept_timeout");
      req_valid = 1'b0;
      return;
    end
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    e.acc   = cyc;
    e.err   = exp_err(a);
    e.rdata = '0;
    e.chk   = 1'b1;
    if (!e.err) begin
      idx = int'((a - BASE) / 4);
      if (w) begin
        mdl[idx]   = d;
        known[idx] = 1'b1;
      end else begin
        e.chk   = known[idx];
        e.rdata = mdl[idx];
      end
    end
    sb.push_back(e);
  endtask

  task automatic wait_idle();
    for (int i = 0; i < 500 && sb.size() != 0; i++) @(negedge clk);
    if (sb.size() != 0) fail_now("drain_timeout");
    repeat (2) @(negedge clk);
  endtask

  // Randomized response backpressure, changed well away from the sampling edge.
  initial begin
    forever begin
      @(posedge clk);
      #1;
      resp_ready = rr_force0 ? 1'b0 : ($urandom_range(0, 3) != 0);
    end
  end

  // Monitor: latency on the first valid cycle, stability while stalled, scoreboard on handshake.
  initial begin
    bit          pv;
    logic [31:0] prd;
    logic        pe;
    exp_t        e;
    pv = 1'b0;
    prd = '0;
    pe = 1'b0;
    forever begin
      @(negedge clk);
      if (resp_valid) begin
        if (!pv) begin
          if (sb.size() == 0) fail_now("spurious_resp");
          else check("latency", 32'(cyc - sb[0].acc), 32'(LAT + 1));
        end else begin
          check("hold_rdata", resp_rdata, prd);
          check("hold_err", 32'(resp_err), 32'(pe));
        end
        if (resp_ready) begin
          if (sb.size() == 0) begin
            fail_now("resp_without_request");
          end else begin
            e = sb.pop_front();
            check("resp_err", 32'(resp_err), 32'(e.err));
            if (e.chk) check("resp_rdata", resp_rdata, e.rdata);
            if (e.err) model_errs++;
          end
        end
      end
      pv  = resp_valid && !resp_ready;
      prd = resp_rdata;
      pe  = resp_err;
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog expired (cycle %0d)", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] hr;
    logic        he;
    bit          got;
    int          kind;
    logic [31:0] a;

    for (int i = 0; i < DEPTH; i++) begin
      mdl[i]   = '0;
      known[i] = 1'b0;
    end

    repeat (3) @(negedge clk);
    check("rst_req_ready", 32'(req_ready), 32'd1);
    check("rst_resp_valid", 32'(resp_valid), 32'd0);
    check("rst_resp_rdata", resp_rdata, 32'd0);
    check("rst_resp_err", 32'(resp_err), 32'd0);
    rst = 1'b0;
    @(negedge clk);

    // Basic writes and reads, including a never-written word.
    req(1'b1, 32'd16, 32'h12345678);
    req(1'b1, 32'd24, 32'h89abcdef);
    req(1'b0, 32'd16, 32'h0);
    req(1'b0, 32'd20, 32'h0);
    req(1'b0, 32'd24, 32'h0);
    // Misaligned read, then confirm the array is intact.
    req(1'b0, 32'd18, 32'h0);
    req(1'b0, 32'd16, 32'h0);
    // One past the top of the array, then the last valid word.
    req(1'b1, 32'd256, 32'hcafef00d);
    req(1'b0, 32'd252, 32'h0);
    wait_idle();

    // Hold the response for five cycles; a request pulse must be ignored.
    rr_force0 = 1'b1;
    req(1'b0, 32'd24, 32'h0);
    got = 1'b0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (resp_valid) begin
        got = 1'b1;
        break;
      end
    end
    if (!got) fail_now("hold_resp_timeout");
    hr = resp_rdata;
    he = resp_err;
    check("hold_first_rdata", hr, 32'h89abcdef);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("stall_valid", 32'(resp_valid), 32'd1);
      check("stall_rdata", resp_rdata, hr);
      check("stall_err", 32'(resp_err), 32'(he));
      check("stall_req_ready", 32'(req_ready), 32'd0);
      if (i == 1) begin
        req_write = 1'b1;
        req_addr  = 32'd40;
        req_wdata = 32'h55aa55aa;
        req_valid = 1'b1;
      end else begin
        req_valid = 1'b0;
      end
    end
    req_valid = 1'b0;
    rr_force0 = 1'b0;
    wait_idle();

    // Reset during BUSY of a write: outputs reset immediately, write dropped.
    req(1'b1, 32'd32, 32'h0);
    wait_idle();
    @(negedge clk);
    req_valid = 1'b1;
    req_write = 1'b1;
    req_addr  = 32'd32;
    req_wdata = 32'hdeadbeef;
    got = 1'b0;
    for (int i = 0; i < 50; i++) begin
      if (req_ready) begin
        got = 1'b1;
        break;
      end
      @(negedge clk);
    end
    if (!got) fail_now("rst_accept_timeout");
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    check("busy_req_ready", 32'(req_ready), 32'd0);
    #2;
    rst = 1'b1;
    #1;
    check("arst_req_ready", 32'(req_ready), 32'd1);
    check("arst_resp_valid", 32'(resp_valid), 32'd0);
    check("arst_resp_rdata", resp_rdata, 32'd0);
    check("arst_resp_err", 32'(resp_err), 32'd0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
`ifdef MEM_RESP_ERR_COUNT_EN
    model_errs = 0;
`endif
    req(1'b0, 32'd32, 32'h0);
    wait_idle();

    // Randomized traffic over a small window so reads hit earlier writes.
    for (int n = 0; n < 80; n++) begin
      kind = int'($urandom_range(0, 9));
      if (kind < 6)      a = 32'($urandom_range(0, 15)) * 32'd4;
      else if (kind < 8) a = 32'($urandom_range(0, 15)) * 32'd4 + 32'($urandom_range(1, 3));
      else if (kind < 9) a = 32'd256 + 32'($urandom_range(0, 7)) * 32'd4;
      else               a = 32'hfffffffc;
      req(1'($urandom_range(0, 1)), a, $urandom);
    end
    wait_idle();

`ifdef MEM_RESP_ERR_COUNT_EN
    check("err_count_random", 32'(err_count), 32'(model_errs > 255 ? 255 : model_errs));
    req(1'b0, 32'd1, 32'h0);
    req(1'b1, 32'd6, 32'h1);
    req(1'b0, 32'd11, 32'h0);
    req(1'b0, 32'd0, 32'h0);
    wait_idle();
    check("err_count_plus3", 32'(err_count), 32'(model_errs > 255 ? 255 : model_errs));
    for (int n = 0; n < 300; n++) req(1'b0, 32'd2, 32'h0);
    wait_idle();
    check("err_count_sat", 32'(err_count), 32'd255);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
